// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory interface.
//   - dm_ctrl access-width codes (word / half / byte, signed or unsigned)
//   - FSM state enum for dmem_if
//   - be_gen   : byte enables for a given width and address offset
//   - load_ext : lane select plus sign/zero extension of a RAM word
package dmem_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } dmem_state_e;

    // Codes 101-111 fall into the default arm and behave as word.
    function automatic logic [3:0] be_gen(input logic [2:0] ctrl, input logic [1:0] a);
        logic [3:0] be;
        case (ctrl)
            dm_halfword, dm_halfword_unsigned: be = a[1] ? 4'b1100 : 4'b0011;
            dm_byte, dm_byte_unsigned:         be = 4'b0001 << a;
            default:                           be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] ctrl, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? w[31:16] : w[15:0];
        b = w[{a, 3'b000} +: 8];
        case (ctrl)
            dm_halfword:          r = {{16{h[15]}}, h};
            dm_halfword_unsigned: r = {16'h0000, h};
            dm_byte:              r = {{24{b[7]}}, b};
            dm_byte_unsigned:     r = {24'h000000, b};
            default:              r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_fmt.sv
// dmem_fmt: combinational lane logic shared by memory-side interfaces.
// Ports:
//   dm_ctrl_i  access width/sign code
//   addr_lo_i  byte offset within the word (addr[1:0])
//   wdata_i    store value, right-justified
//   rword_i    raw word read from RAM
//   be_o       byte enables
//   wdata_o    store value replicated across all lanes of its width
//   rdata_o    selected lane, sign/zero extended
//   aligned_o  access is naturally aligned for its width
module dmem_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  dm_ctrl_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        aligned_o
);

    always_comb begin
        be_o    = be_gen(dm_ctrl_i, addr_lo_i);
        rdata_o = load_ext(dm_ctrl_i, addr_lo_i, rword_i);
        case (dm_ctrl_i)
            dm_halfword, dm_halfword_unsigned: begin
                wdata_o   = {2{wdata_i[15:0]}};
                aligned_o = ~addr_lo_i[0];
            end
            dm_byte, dm_byte_unsigned: begin
                wdata_o   = {4{wdata_i[7:0]}};
                aligned_o = 1'b1;
            end
            default: begin
                wdata_o   = wdata_i;
                aligned_o = (addr_lo_i == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory interface to a variable-latency word RAM.
// Ports:
//   clk, reset (async, active-low)
//   mem_r / mem_w / addr / wdata / dm_ctrl   CPU MEM-stage request
//   rdata      registered, formatted load data (valid in DONE)
//   stall      holds IF..MEM until the transaction completes
//   misalign   current request is misaligned (no RAM access)
//   bus_err    one-cycle pulse when the RAM does not respond in TIMEOUT cycles
//   ram_*      request/grant/rvalid handshake to the word-wide RAM
module dmem_if
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        ram_req,
    output logic        ram_we,
    output logic [29:0] ram_addr,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic        ram_gnt,
    input  logic        ram_rvalid,
    input  logic [31:0] ram_rdata
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      rdata_q;
    logic             bus_err_q;
    logic             ram_req_q;
    logic             ram_we_q;
    logic [29:0]      ram_addr_q;
    logic [3:0]       ram_be_q;
    logic [31:0]      ram_wdata_q;

    logic             req_any;
    logic             req_ok;
    logic             timeout;
    logic [3:0]       fmt_be;
    logic [31:0]      fmt_wdata;
    logic [31:0]      fmt_rdata;
    logic             fmt_aligned;

    dmem_fmt u_fmt (
        .dm_ctrl_i (dm_ctrl),
        .addr_lo_i (addr[1:0]),
        .wdata_i   (wdata),
        .rword_i   (ram_rdata),
        .be_o      (fmt_be),
        .wdata_o   (fmt_wdata),
        .rdata_o   (fmt_rdata),
        .aligned_o (fmt_aligned)
    );

    assign req_any  = mem_r | mem_w;
    assign misalign = req_any & ~fmt_aligned;
    assign req_ok   = req_any & fmt_aligned;
    // DONE is the cycle the pipeline advances, so stall is released there.
    assign stall    = req_ok & (state_q != DONE);

    // Saturating watchdog increment; timeout fires on the edge where the
    // counter would reach TIMEOUT.
    assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout  = (cnt_q == CNT_LAST);

    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_be    = ram_be_q;
    assign ram_wdata = ram_wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_ok) begin
                        state_q     <= REQ;
                        cnt_q       <= '0;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= mem_w;
                        ram_addr_q  <= addr[31:2];
                        ram_be_q    <= fmt_be;
                        ram_wdata_q <= fmt_wdata;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (ram_gnt) begin
                        ram_req_q <= 1'b0;
                        if (ram_we_q) begin
                            state_q <= DONE;
                        end else if (ram_rvalid) begin
                            // Grant and data in the same cycle: skip WAIT_R.
                            rdata_q <= fmt_rdata;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT_R;
                        end
                    end else if (timeout) begin
                        // Un-granted request (store or load) is dropped.
                        ram_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        rdata_q   <= '0;
                        state_q   <= DONE;
                    end
                end
                WAIT_R: begin
                    cnt_q <= cnt_d;
                    if (ram_rvalid) begin
                        rdata_q <= fmt_rdata;
                        state_q <= DONE;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        rdata_q   <= '0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_if.sv
module tb_dmem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w;
    logic [31:0] addr, wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err;
    logic        ram_req, ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        ram_gnt, ram_rvalid;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    dmem_if #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .addr       (addr),
        .wdata      (wdata),
        .dm_ctrl    (dm_ctrl),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .ram_gnt    (ram_gnt),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata)
    );

    // ---------------- RAM model ----------------
    logic [31:0] ram [0:63];
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    bit          gnt_en  = 1'b1;
    bit          rv_en   = 1'b1;
    int          req_age = 0;
    int          rd_age  = 0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_word = 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    assign ram_gnt    = ram_req && gnt_en && (req_age >= gnt_dly);
    assign ram_rvalid = rv_en && ((rd_pend && rd_age >= rv_dly) ||
                                  (ram_gnt && !ram_we && rv_dly == 0));
    assign ram_rdata  = rd_pend ? rd_word : ram[ram_addr[5:0]];

    always @(posedge clk) begin
        req_age <= (ram_req && !ram_gnt) ? req_age + 1 : 0;
        if (ram_gnt && ram_we)
            ram[ram_addr[5:0]] <= merge(ram[ram_addr[5:0]], ram_wdata, ram_be);
        if (ram_gnt && !ram_we && !ram_rvalid) begin
            rd_pend <= 1'b1;
            rd_age  <= 1;
            rd_word <= ram[ram_addr[5:0]];
        end else if (rd_pend) begin
            if (ram_rvalid || !stall || !reset) rd_pend <= 1'b0;
            else rd_age <= rd_age + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } ram_exp_t;

    typedef struct {
        logic        mis;
        logic        berr;
        int          stalls;
        logic        chk_rd;
        logic [31:0] rdata;
    } cmp_exp_t;

    ram_exp_t ramq[$];
    cmp_exp_t cmpq[$];

    int n_chk = 0, n_pass = 0;
    int exp_reqs = 0;
    int hs_cnt = 0, req_cnt = 0, berr_cnt = 0, stall_cnt = 0;
    logic req_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: RAM handshakes and instruction completions.
    always @(negedge clk) begin
        if (reset) begin
            if (ram_req && ram_gnt) begin
                hs_cnt++;
                if (ramq.size() == 0) begin
                    chk("unexpected_ram_access", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    ram_exp_t e;
                    e = ramq.pop_front();
                    chk("ram_we", 32'(ram_we), 32'(e.we));
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    chk("ram_be", 32'(ram_be), 32'(e.be));
                    if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
                end
            end
            if (mem_r || mem_w) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (cmpq.size() == 0) begin
                        chk("unexpected_completion", addr, 32'hFFFF_FFFF);
                    end else begin
                        cmp_exp_t c;
                        c = cmpq.pop_front();
                        chk("misalign", 32'(misalign), 32'(c.mis));
                        chk("bus_err", 32'(bus_err), 32'(c.berr));
                        chk("stall_cycles", 32'(stall_cnt), 32'(c.stalls));
                        if (c.chk_rd) chk("rdata", rdata, c.rdata);
                    end
                    stall_cnt = 0;
                end
            end
            if (bus_err) berr_cnt++;
            if (ram_req && !req_prev) req_cnt++;
            req_prev = ram_req;
        end else begin
            req_prev = 1'b0;
        end
    end

    // Drive one instruction and hold it until the DUT releases stall.
    // Called at posedge+1; returns at posedge+1 after the completing cycle.
    task automatic issue(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] c,
                         input int gd, input int rd, input bit ren,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic emis, input logic eberr, input int estall,
                         input logic [31:0] erd);
        ram_exp_t re;
        cmp_exp_t ce;
        bit done;
        gnt_dly = gd;
        rv_dly  = rd;
        rv_en   = ren;
        if (!emis) begin
            re.we = w; re.addr = a[31:2]; re.be = ebe; re.wdata = ewd;
            ramq.push_back(re);
            exp_reqs++;
        end
        ce.mis = emis; ce.berr = eberr; ce.stalls = estall;
        ce.chk_rd = r & ~emis; ce.rdata = erd;
        cmpq.push_back(ce);
        mem_r = r; mem_w = w; addr = a; wdata = wd; dm_ctrl = c;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("completion_timeout", addr, 32'h0);
        @(posedge clk);
        #1;
        rv_en = 1'b1;
    endtask

    localparam logic [2:0] W = 3'b000, H = 3'b001, HU = 3'b010, B = 3'b011, BU = 3'b100;

    initial begin
        reset = 1'b0;
        mem_r = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; dm_ctrl = W;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ram_req", 32'(ram_req), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_be", 32'(ram_be), 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        //      r  w  addr      wdata         ctrl gd rd ren be       ewdata        mis berr st erdata
        issue(0, 1, 32'h100, 32'hDEADBEEF, W,  0, 1, 1, 4'b1111, 32'hDEADBEEF, 0, 0, 2, 32'h0);
        issue(0, 1, 32'h103, 32'h123456A5, B,  3, 1, 1, 4'b1000, 32'hA5A5A5A5, 0, 0, 5, 32'h0);
        issue(0, 1, 32'h100, 32'h80017FFF, W,  0, 1, 1, 4'b1111, 32'h80017FFF, 0, 0, 2, 32'h0);
        issue(1, 0, 32'h102, 32'h0,        H,  0, 1, 1, 4'b1100, 32'h0,        0, 0, 3, 32'hFFFF8001);
        issue(1, 0, 32'h102, 32'h0,        HU, 0, 0, 1, 4'b1100, 32'h0,        0, 0, 2, 32'h00008001);
        issue(1, 0, 32'h100, 32'h0,        B,  1, 2, 1, 4'b0001, 32'h0,        0, 0, 5, 32'hFFFFFFFF);
        issue(1, 0, 32'h101, 32'h0,        W,  0, 1, 1, 4'b1111, 32'h0,        1, 0, 0, 32'h0);
        issue(1, 0, 32'h103, 32'h0,        BU, 0, 1, 1, 4'b1000, 32'h0,        0, 0, 3, 32'h00000080);
        issue(1, 0, 32'h100, 32'h0,        W,  0, 1, 0, 4'b1111, 32'h0,        0, 1, 9, 32'h0);
        issue(0, 1, 32'h104, 32'hCAFEF00D, W,  0, 1, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 2, 32'h0);
        issue(1, 0, 32'h104, 32'h0,        W,  0, 1, 1, 4'b1111, 32'h0,        0, 0, 3, 32'hCAFEF00D);
        issue(1, 0, 32'h104, 32'h0,    3'b111, 0, 1, 1, 4'b1111, 32'h0,        0, 0, 3, 32'hCAFEF00D);
        issue(0, 1, 32'h106, 32'h0000BEEF, H,  0, 1, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 2, 32'h0);
        issue(1, 0, 32'h106, 32'h0,        HU, 0, 1, 1, 4'b1100, 32'h0,        0, 0, 3, 32'h0000BEEF);
        issue(1, 0, 32'h101, 32'h0,        H,  0, 1, 1, 4'b0011, 32'h0,        1, 0, 0, 32'h0);
        mem_r = 1'b0; mem_w = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ram_q_drained", 32'(ramq.size()), 32'h0);
        chk("cmp_q_drained", 32'(cmpq.size()), 32'h0);
        chk("bus_err_pulses", 32'(berr_cnt), 32'h1);
        chk("ram_requests", 32'(req_cnt), 32'(exp_reqs));
        chk("ram_handshakes", 32'(hs_cnt), 32'(exp_reqs));

        // Reset in the middle of an un-granted request drops ram_req at once.
        gnt_en = 1'b0;
        @(posedge clk);
        #1;
        mem_r = 1'b1; addr = 32'h100; dm_ctrl = W;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_req_active", 32'(ram_req), 32'h1);
        reset = 1'b0;
        mem_r = 1'b0;
        #1;
        chk("mid_reset_ram_req", 32'(ram_req), 32'h0);
        chk("mid_reset_rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
